// File: rtl/ysyx_24100006_exeu_md.sv
// RV M-extension execute unit: multi-cycle multiply and restoring divide, with
// a zero-latency bypass that forwards the external ALU result for non-M ops.
module ysyx_24100006_exeu_md #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            flush,
  input  logic            is_m,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [3:0]      rd_i,
  input  logic            gpr_we_i,
  output logic [3:0]      rd_o,
  output logic            gpr_we_o,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and flush suppresses both for that cycle.

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MSB_ONLY = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_result;
  logic [3:0]      r_rd;
  logic            r_we;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_special;

  logic            w_accept;
  logic            w_bypass;

  // Divide operand preparation at accept time
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec_res;

  // Multiplier
  logic [2:0]        w_mul_op;
  logic [XLEN-1:0]   w_mul_a;
  logic [XLEN-1:0]   w_mul_b;
  logic              w_mul_sa;
  logic              w_mul_sb;
  logic [2*XLEN-1:0] w_mul_ax;
  logic [2*XLEN-1:0] w_mul_bx;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;

  // Restoring divide step
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;
  logic            w_q_bit;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_div_res;

  assign w_accept = reset && !flush && (r_state == S_IDLE) && is_m && in_valid;
  assign w_bypass = reset && (r_state == S_IDLE) && !is_m;

  assign w_a_neg    = !funct3[0] && a[XLEN-1];
  assign w_b_neg    = !funct3[0] && b[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag    = w_b_neg ? (~b + 1'b1) : b;
  assign w_div0     = (b == '0);
  assign w_ovf      = !funct3[0] && (a == MSB_ONLY) && (&b);
  assign w_spec_res = w_div0 ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);

  // In IDLE the product is taken straight from the inputs (single-cycle case)
  assign w_mul_op  = (r_state == S_IDLE) ? funct3 : r_op;
  assign w_mul_a   = (r_state == S_IDLE) ? a : r_a;
  assign w_mul_b   = (r_state == S_IDLE) ? b : r_b;
  assign w_mul_sa  = (w_mul_op[1:0] == 2'b01) || (w_mul_op[1:0] == 2'b10);
  assign w_mul_sb  = (w_mul_op[1:0] == 2'b01);
  assign w_mul_ax  = {{XLEN{w_mul_sa && w_mul_a[XLEN-1]}}, w_mul_a};
  assign w_mul_bx  = {{XLEN{w_mul_sb && w_mul_b[XLEN-1]}}, w_mul_b};
  assign w_prod    = w_mul_ax * w_mul_bx;
  assign w_mul_res = (w_mul_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // r_a holds the dividend magnitude shifting out MSB-first while quotient bits shift in
  assign w_rem_sh  = {r_rem, r_a[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_q_bit   = !w_diff[XLEN];
  assign w_rem_nxt = w_q_bit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_nxt = {r_a[XLEN-2:0], w_q_bit};
  assign w_div_res = r_op[1] ? (r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt)
                             : (r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (funct3[2]) begin
            w_state_nxt = S_DIV;
          end else if (MUL_LAT == 1) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_MUL;
          end
        end
      end
      S_MUL:   if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DIV:   if (r_special || (r_cnt == CW'(1))) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rem     <= '0;
      r_result  <= '0;
      r_rd      <= '0;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
    end else if (w_accept) begin
      r_op  <= funct3;
      r_rd  <= rd_i;
      r_we  <= gpr_we_i;
      r_rem <= '0;
      if (funct3[2]) begin
        r_a       <= w_a_mag;
        r_b       <= w_b_mag;
        r_cnt     <= CW'(XLEN);
        r_neg_q   <= w_a_neg ^ w_b_neg;
        r_neg_r   <= w_a_neg;
        r_special <= w_div0 || w_ovf;
        r_result  <= w_spec_res;
      end else begin
        r_a       <= a;
        r_b       <= b;
        r_cnt     <= CW'(MUL_LAT - 1);
        r_neg_q   <= 1'b0;
        r_neg_r   <= 1'b0;
        r_special <= 1'b0;
        r_result  <= w_mul_res;
      end
    end else if (!flush) begin
      case (r_state)
        S_MUL: begin
          if (r_cnt == '0) begin
            r_result <= w_mul_res;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (!r_special) begin
            r_a   <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_result <= w_div_res;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (reset && !flush) begin
      case (r_state)
        S_IDLE: begin
          in_ready  = is_m ? 1'b1 : out_ready;
          out_valid = is_m ? 1'b0 : in_valid;
        end
        S_DONE:  out_valid = 1'b1;
        default: ;
      endcase
    end
  end

  assign result    = w_bypass ? alu_result_i : r_result;
  assign rd_o      = w_bypass ? rd_i : r_rd;
  assign gpr_we_o  = w_bypass ? gpr_we_i : r_we;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ysyx_24100006_exeu_md.sv
// Directed bench for the M-extension execute unit at XLEN=32, MUL_LAT=3.
module tb_ysyx_24100006_exeu_md;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic            flush;
  logic            is_m;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] alu_result_i;
  logic [3:0]      rd_i;
  logic            gpr_we_i;
  logic [3:0]      rd_o;
  logic            gpr_we_o;
  logic [XLEN-1:0] result;
  logic            busy;
  logic [1:0]      dbg_state;

  int checks;
  int errors;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic [2:0]      f3;
    logic [XLEN-1:0] av;
    logic [XLEN-1:0] bv;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  vec_t vecs[25];

  ysyx_24100006_exeu_md #(.XLEN(XLEN), .MUL_LAT(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .flush        (flush),
    .is_m         (is_m),
    .funct3       (funct3),
    .a            (a),
    .b            (b),
    .alu_result_i (alu_result_i),
    .rd_i         (rd_i),
    .gpr_we_i     (gpr_we_i),
    .rd_o         (rd_o),
    .gpr_we_o     (gpr_we_o),
    .result       (result),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for out_valid at negedges, returning edges since the accept edge.
  task automatic wait_valid(output int edges);
    edges = 0;
    @(negedge clk);
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [XLEN-1:0] av,
                        input logic [XLEN-1:0] bv, input logic [XLEN-1:0] exp_res,
                        input int exp_lat, input logic [3:0] rd, input logic we);
    int edges;
    logic [XLEN-1:0] exp_v;
    @(negedge clk);
    is_m = 1'b1; funct3 = f3; a = av; b = bv; rd_i = rd; gpr_we_i = we;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    exp_q.push_back(exp_res);
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = '0; b = '0; rd_i = '0; gpr_we_i = 1'b0; funct3 = 3'b000;
    wait_valid(edges);
    check({name, "_lat"}, 64'(edges), 64'(exp_lat));
    exp_v = exp_q.pop_front();
    check({name, "_result"}, 64'(result), 64'(exp_v));
    check({name, "_rd"}, 64'(rd_o), 64'(rd));
    check({name, "_we"}, 64'(gpr_we_o), 64'(we));
    @(posedge clk);
    @(negedge clk);
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int edges;
    logic seen;
    checks = 0;
    errors = 0;

    //               f3      a             b             expected      lat
    vecs[0]  = '{3'b100, 32'd7,        32'd2,        32'd3,        32};
    vecs[1]  = '{3'b110, 32'd7,        32'd2,        32'd1,        32};
    vecs[2]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32};
    vecs[3]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32};
    vecs[4]  = '{3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 1};
    vecs[5]  = '{3'b111, 32'h1234,     32'd0,        32'h1234,     1};
    vecs[6]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[7]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[8]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        3};
    vecs[9]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3};
    vecs[10] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3};
    vecs[11] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        3};
    vecs[12] = '{3'b000, 32'd3,        32'd4,        32'd12,       3};
    vecs[13] = '{3'b101, 32'd100,      32'd7,        32'd14,       32};
    vecs[14] = '{3'b111, 32'd100,      32'd7,        32'd2,        32};
    vecs[15] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32};
    vecs[16] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        32};
    vecs[17] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32};
    vecs[18] = '{3'b011, 32'h80000000, 32'd2,        32'd1,        3};
    vecs[19] = '{3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1};
    vecs[20] = '{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1};
    vecs[21] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 3};
    vecs[22] = '{3'b100, 32'h80000000, 32'd1,        32'h80000000, 32};
    vecs[23] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32};
    vecs[24] = '{3'b010, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 3};

    // Reset held with a live bypass request
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0; is_m = 1'b0;
    funct3 = 3'b000; a = '0; b = '0; alu_result_i = 32'hDEADBEEF; rd_i = 4'd3; gpr_we_i = 1'b1;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_rd", 64'(rd_o), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;

    // Bypass is purely combinational
    @(negedge clk);
    in_valid = 1'b1; alu_result_i = 32'hCAFE0001; rd_i = 4'd7; gpr_we_i = 1'b1;
    #1;
    check("byp_out_valid", 64'(out_valid), 64'd1);
    check("byp_in_ready", 64'(in_ready), 64'd1);
    check("byp_result", 64'(result), 64'hCAFE0001);
    check("byp_rd", 64'(rd_o), 64'd7);
    check("byp_we", 64'(gpr_we_o), 64'd1);
    out_ready = 1'b0;
    #1;
    check("byp_bp_in_ready", 64'(in_ready), 64'd0);
    check("byp_bp_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    #1;
    check("byp_no_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;

    // Table-driven operations
    for (int i = 0; i < 25; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].av, vecs[i].bv, vecs[i].exp,
             vecs[i].lat, 4'(i), i[0]);
    end

    // Backpressure in DONE, with a competing request that must not be taken
    @(negedge clk);
    is_m = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd7; rd_i = 4'd5; gpr_we_i = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    funct3 = 3'b000; a = 32'd3; b = 32'd3; rd_i = 4'd2; gpr_we_i = 1'b0;
    wait_valid(edges);
    check("bp_lat", 64'(edges), 64'd32);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_result_%0d", i), 64'(result), 64'd14);
      check($sformatf("bp_rd_%0d", i), 64'(rd_o), 64'd5);
      check($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
      check($sformatf("bp_out_valid_%0d", i), 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle", 64'(busy), 64'd0);
    check("bp_out_valid_low", 64'(out_valid), 64'd0);

    // Flush beats a pending accept
    @(negedge clk);
    is_m = 1'b1; funct3 = 3'b100; a = 32'd9; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
    #1;
    check("flacc_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flacc_idle", 64'(busy), 64'd0);

    // Flush at divide iteration 10
    @(negedge clk);
    is_m = 1'b1; funct3 = 3'b100; a = 32'd7; b = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
      @(posedge clk);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl_busy_before", 64'(busy), 64'd1);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("fl_state", 64'(dbg_state), 64'd0);
    for (int i = 0; i < 40; i++) begin
      seen = seen | out_valid;
      @(negedge clk);
    end
    check("fl_never_valid", 64'(seen), 64'd0);
    run_op("fl_mul", 3'b000, 32'd3, 32'd4, 32'd12, 3, 4'd11, 1'b1);

    // Reset mid-divide, then a fresh divide
    @(negedge clk);
    is_m = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd7; rd_i = 4'd9; gpr_we_i = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd0);
    check("mrst_result", 64'(result), 64'd0);
    check("mrst_rd", 64'(rd_o), 64'd0);
    check("mrst_we", 64'(gpr_we_o), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("mrst_divu", 3'b101, 32'd100, 32'd7, 32'd14, 32, 4'd9, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
